axis_peak_sched: RTL and testbench

//  Round-robin burst scheduler that shares one downstream AXI-stream (host packetizer / DMA) among
//  NUM_SOURCES peak-detector instances. Each detector emits fixed-length bursts terminated by tlast.
//  The scheduler grants one whole burst at a time and prefixes it with a header word
//  (timestamp, source, sequence number). After the burst it enforces a hold-off gap.
//  It aborts bursts that stall upstream, so one failed detector cannot lock the shared output.

---
 rtl/axis_peak_sched_pkg.sv | 38 +++
 rtl/axis_peak_sched_arb_rr.sv | 35 +++
 rtl/axis_peak_sched.sv | 185 ++++++++++++++++++
 tb/tb_axis_peak_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_peak_sched_pkg.sv
// Shared definitions for the peak-detector burst scheduler: header field
// layout (also used by the downstream parser), FSM state encodings and
// width helpers.
package axis_peak_sched_pkg;

  // Header word layout; bits above the sequence field are zero.
  localparam int HDR_TS_LSB  = 0;
  localparam int HDR_TS_W    = 32;
  localparam int HDR_SRC_LSB = 32;
  localparam int HDR_SRC_W   = 8;
  localparam int HDR_SEQ_LSB = 40;
  localparam int HDR_SEQ_W   = 16;

  // Scheduler states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    DATA    = 3'd2,
    ABORT   = 3'd3,
    HOLDOFF = 3'd4
  } sched_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int func_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? func_log2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_peak_sched_arb_rr.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr, wrapping cyclically. Returns the grant one-hot and as an index.
module arb_rr
  import axis_peak_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int  cand;
  logic found;

  // Scan N positions starting at ptr; the first active request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/axis_peak_sched.sv
// Round-robin burst scheduler sharing one AXI-stream master among several
// peak-detector sources. Each granted burst is prefixed with a header word
// (timestamp, source, sequence), followed by a hold-off gap. A source that
// stalls mid-burst is cut off with a single abort beat so it cannot lock
// the shared output.
module axis_peak_sched
  import axis_peak_sched_pkg::*;
#(
  parameter int NUM_SOURCES    = 2,
  parameter int DATA_WIDTH     = 128,
  parameter int HOLDOFF_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]            s_axis_tready,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic [15:0]                       stat_bursts,
  output logic [15:0]                       stat_aborts
);

  localparam int IDX_W = idx_width(NUM_SOURCES);
  localparam int TO_W  = func_log2(TIMEOUT_CYCLES) + 1;
  localparam int HO_W  = func_log2(HOLDOFF_CYCLES) + 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

  sched_state_e            state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        grant;
  logic [31:0]             ts;
  logic [31:0]             ts_cap;
  logic [15:0]             seq;
  logic [TO_W-1:0]         to_cnt;
  logic [HO_W-1:0]         ho_cnt;

  logic [NUM_SOURCES-1:0]  arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    any_req;

  logic                    src_vld;
  logic                    src_last;
  logic [DATA_WIDTH-1:0]   src_data;
  logic                    to_expire;
  logic [IDX_W-1:0]        next_ptr;
  logic [DATA_WIDTH-1:0]   hdr_word;

  arb_rr #(
    .N  (NUM_SOURCES),
    .IW (IDX_W)
  ) u_arb (
    .req (s_axis_tvalid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign any_req   = |arb_gnt;
  assign src_vld   = s_axis_tvalid[grant];
  assign src_last  = s_axis_tlast[grant];
  assign src_data  = s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
  // Timeout fires on the cycle the counter sits at its last value with the
  // source still idle; a valid beat on that cycle always wins.
  assign to_expire = !src_vld && (to_cnt == TO_LAST);
  assign next_ptr  = (grant == LAST_IDX) ? '0 : grant + 1'b1;

  // Assemble the header word from the captured grant state.
  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_TS_LSB  +: HDR_TS_W]  = ts_cap;
    hdr_word[HDR_SRC_LSB +: HDR_SRC_W] = HDR_SRC_W'(grant);
    hdr_word[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
  end

  // Free-running timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else begin
      ts <= ts + 32'd1;
    end
  end

  // Scheduler FSM: arbitration, header, pass-through, abort and hold-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      ts_cap      <= '0;
      seq         <= '0;
      to_cnt      <= '0;
      ho_cnt      <= '0;
      stat_bursts <= '0;
      stat_aborts <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= arb_idx;
            ts_cap <= ts;
            state  <= HEADER;
          end
        end
        HEADER: begin
          if (m_axis_tready) begin
            to_cnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (src_vld) begin
            to_cnt <= '0;
            if (m_axis_tready && src_last) begin
              stat_bursts <= stat_bursts + 16'd1;
              seq         <= seq + 16'd1;
              rr_ptr      <= next_ptr;
              ho_cnt      <= '0;
              state       <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
            end
          end else if (to_expire) begin
            state <= ABORT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (m_axis_tready) begin
            stat_aborts <= stat_aborts + 16'd1;
            seq         <= seq + 16'd1;
            rr_ptr      <= next_ptr;
            ho_cnt      <= '0;
            state       <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (ho_cnt == HO_LAST) begin
            state <= IDLE;
          end else begin
            ho_cnt <= ho_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering; payload passes straight through from the granted source.
  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state)
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tuser  = 1'b1;
        m_axis_tdata  = hdr_word;
      end
      DATA: begin
        m_axis_tvalid        = src_vld;
        m_axis_tdata         = src_data;
        m_axis_tlast         = src_last;
        s_axis_tready[grant] = m_axis_tready && !to_expire;
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axis_peak_sched.sv
// Scoreboard bench for axis_peak_sched: the stimulus process drives the
// source models and queues the expected master beats; a monitor process
// compares every presented master beat with the head of that queue.
module tb_axis_peak_sched;

  localparam int NS   = 2;
  localparam int DW   = 128;
  localparam int HOLD = 64;
  localparam int TMO  = 256;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    bit            is_hdr;
    bit            pay;
    int            gap;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS-1:0]     s_axis_tready;
  logic [NS*DW-1:0]  s_axis_tdata;
  logic [NS-1:0]     s_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [15:0]       stat_bursts;
  logic [15:0]       stat_aborts;

  int checks   = 0;
  int failures = 0;

  exp_t        q[$];
  logic [31:0] tsm;
  int          pay_hs = 0;
  bit          bp = 1'b0;

  int rem[NS], nb[NS], len[NS], beat[NS], bnum[NS], stall[NS];

  always #5 clk = ~clk;

  axis_peak_sched #(
    .NUM_SOURCES    (NS),
    .DATA_WIDTH     (DW),
    .HOLDOFF_CYCLES (HOLD),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .stat_bursts   (stat_bursts),
    .stat_aborts   (stat_aborts)
  );

  // Reference timestamp: counts clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tsm <= '0;
    else        tsm <= tsm + 32'd1;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int s, input int b, input int k);
    logic [DW-1:0] d;
    d = '0;
    d[127:120] = 8'(s + 160);
    d[119:104] = 16'(b);
    d[103:88]  = 16'(k);
    d[63:32]   = 32'(s * 7919 + b * 31 + k);
    d[31:0]    = 32'hDEAD_0000 | 32'(k);
    return d;
  endfunction

  task automatic drive_src();
    for (int i = 0; i < NS; i++) begin
      s_axis_tvalid[i] = (rem[i] > 0) && !(stall[i] >= 0 && beat[i] >= stall[i]);
      s_axis_tdata[i*DW +: DW] = pat(i, bnum[i], beat[i]);
      s_axis_tlast[i] = (rem[i] == 1);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NS; i++) begin
      rem[i] = 0; nb[i] = 0; len[i] = 0; beat[i] = 0; bnum[i] = 0; stall[i] = -1;
    end
    drive_src();
  endtask

  task automatic load(input int s, input int nbursts, input int length, input int stall_at);
    rem[s] = length; nb[s] = nbursts - 1; len[s] = length; beat[s] = 0; stall[s] = stall_at;
    drive_src();
  endtask

  // One clock: note source handshakes, then advance the source models.
  task automatic tick();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        beat[i]++;
        rem[i]--;
        if (rem[i] == 0) begin
          bnum[i]++;
          beat[i] = 0;
          if (nb[i] > 0) begin
            nb[i]--;
            rem[i] = len[i];
          end
        end
      end
    end
    if (bp) m_axis_tready = 1'($urandom_range(0, 1));
    drive_src();
  endtask

  task automatic push_hdr(input int s, input int sq, input int gap);
    exp_t e;
    e.data = '0;
    e.data[55:40] = 16'(sq);
    e.data[39:32] = 8'(s);
    e.last = 1'b0; e.user = 1'b1; e.is_hdr = 1'b1; e.pay = 1'b0; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_pay(input int s, input int b, input int nbeats, input int length);
    exp_t e;
    for (int k = 0; k < nbeats; k++) begin
      e.data = pat(s, b, k);
      e.last = (k == length - 1); e.user = 1'b0; e.is_hdr = 1'b0; e.pay = 1'b1; e.gap = -1;
      q.push_back(e);
    end
  endtask

  task automatic push_abort(input int gap);
    exp_t e;
    e.data = '0; e.last = 1'b1; e.user = 1'b1; e.is_hdr = 1'b0; e.pay = 1'b0; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain actual=%0d pending beats required=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    q.delete();
    reset_model();
    bp = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare each presented master beat with the queue head.
  // Header timestamps are taken from the reference counter at first sight;
  // gap counts cycles with m_tvalid low since the previous handshake.
  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] ed;
    logic [31:0]   hdr_ts;
    bit            seen;
    int            gap_cnt;
    seen = 1'b0; gap_cnt = 0; hdr_ts = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        gap_cnt = 0;
      end else if (!m_axis_tvalid) begin
        gap_cnt++;
      end else if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
      end else begin
        e = q[0];
        if (!seen) begin
          seen = 1'b1;
          if (e.is_hdr) hdr_ts = tsm - 32'd1;
          if (e.gap >= 0) chk("gap_cycles", DW'(gap_cnt), DW'(e.gap));
        end
        ed = e.data;
        if (e.is_hdr) ed[31:0] = hdr_ts;
        chk("m_tdata", m_axis_tdata, ed);
        chk("m_tlast", DW'(m_axis_tlast), DW'(e.last));
        chk("m_tuser", DW'(m_axis_tuser), DW'(e.user));
        if (m_axis_tready) begin
          void'(q.pop_front());
          seen = 1'b0;
          gap_cnt = 0;
          if (e.pay) pay_hs++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    int p0, n;
    // Reset with both sources requesting.
    rst_n = 1'b0;
    m_axis_tready = 1'b1;
    reset_model();
    load(0, 1, 4, -1);
    load(1, 1, 4, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", DW'(s_axis_tready), '0);
    chk("rst_m_tvalid", DW'(m_axis_tvalid), '0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tlast_tuser", DW'({m_axis_tlast, m_axis_tuser}), '0);
    chk("rst_stat_bursts", DW'(stat_bursts), '0);
    chk("rst_stat_aborts", DW'(stat_aborts), '0);
    push_hdr(0, 0, -1); push_pay(0, 0, 4, 4);
    push_hdr(1, 1, HOLD + 1); push_pay(1, 0, 4, 4);
    rst_n = 1'b1;
    wait_empty("t1", 400);
    chk("t1_stat_bursts", DW'(stat_bursts), DW'(2));

    // Single 32-beat burst from source 1.
    reset_dut();
    load(1, 1, 32, -1);
    push_hdr(1, 0, -1); push_pay(1, 0, 32, 32);
    wait_empty("t2", 200);
    chk("t2_stat_bursts", DW'(stat_bursts), DW'(1));

    // Contention: both sources always requesting, grants alternate.
    reset_dut();
    load(0, 2, 8, -1);
    load(1, 2, 8, -1);
    push_hdr(0, 0, -1);       push_pay(0, 0, 8, 8);
    push_hdr(1, 1, HOLD + 1); push_pay(1, 0, 8, 8);
    push_hdr(0, 2, HOLD + 1); push_pay(0, 1, 8, 8);
    push_hdr(1, 3, HOLD + 1); push_pay(1, 1, 8, 8);
    wait_empty("t3", 1000);
    chk("t3_stat_bursts", DW'(stat_bursts), DW'(4));

    // Random master backpressure.
    bp = 1'b1;
    load(0, 1, 12, -1);
    load(1, 1, 12, -1);
    push_hdr(0, 4, -1); push_pay(0, 2, 12, 12);
    push_hdr(1, 5, -1); push_pay(1, 2, 12, 12);
    wait_empty("t4", 2000);
    bp = 1'b0;
    m_axis_tready = 1'b1;
    chk("t4_stat_bursts", DW'(stat_bursts), DW'(6));
    chk("t4_stat_aborts", DW'(stat_aborts), '0);

    // Source 0 stalls after 5 beats; burst is aborted, source 1 follows.
    reset_dut();
    load(0, 1, 10, 5);
    load(1, 1, 3, -1);
    push_hdr(0, 0, -1); push_pay(0, 0, 5, 10);
    push_abort(TMO);
    push_hdr(1, 1, HOLD + 1); push_pay(1, 0, 3, 3);
    wait_empty("t5", 1200);
    chk("t5_stat_aborts", DW'(stat_aborts), DW'(1));
    chk("t5_stat_bursts", DW'(stat_bursts), DW'(1));

    // Asynchronous reset in the middle of a burst.
    load(0, 1, 32, -1);
    push_hdr(0, 2, -1); push_pay(0, 0, 32, 32);
    p0 = pay_hs;
    n = 0;
    while (pay_hs - p0 < 10 && n < 400) begin
      tick();
      n++;
    end
    chk("t6_reached_beat10", DW'(pay_hs - p0), DW'(10));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_s_tready", DW'(s_axis_tready), '0);
    chk("t6_m_tvalid", DW'(m_axis_tvalid), '0);
    chk("t6_m_tdata", m_axis_tdata, '0);
    chk("t6_m_tlast_tuser", DW'({m_axis_tlast, m_axis_tuser}), '0);
    chk("t6_stat_bursts", DW'(stat_bursts), '0);
    chk("t6_stat_aborts", DW'(stat_aborts), '0);
    q.delete();
    reset_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    load(1, 1, 2, -1);
    push_hdr(1, 0, -1); push_pay(1, 0, 2, 2);
    wait_empty("t6", 200);
    chk("t6_post_bursts", DW'(stat_bursts), DW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
